// File: rtl/controle_ldst.sv
// controle_ldst: load/store sequencer for the register-file/memory datapath.
// Latches one LOAD or STORE command, forms the memory address through the
// external somador, then steps the registrador and memoria enables.
// The 64-bit data buses are wired block to block and never pass through here.
module controle_ldst (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       op,
   input  logic [4:0] base,
   input  logic [4:0] offset,
   input  logic       sub,
   input  logic [4:0] rd,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [4:0] add_a,
   output logic [4:0] add_b,
   output logic       add_sinal,
   input  logic [5:0] add_res,
   output logic       reg_we,
   output logic [4:0] reg_rw,
   output logic [4:0] reg_ra,
   output logic       mem_we,
   output logic [5:0] mem_ads
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_MRD,
      S_WB,
      S_MWR,
      S_DONE
   } state_t;

   state_t     state_q;
   logic       op_q;
   logic       sub_q;
   logic [4:0] base_q;
   logic [4:0] offset_q;
   logic [4:0] rd_q;
   logic [5:0] addr_q;
   logic       busy_q;
   logic       done_q;
   logic       err_q;
   logic       reg_we_q;
   logic       mem_we_q;
   logic       addr_neg_d;

   // A subtraction that would go below zero is an address error.
   always_comb begin
      addr_neg_d = sub_q && (base_q < offset_q);
   end

   // Sequencer: state, command latch, address register and registered outputs.
   // Write enables are asserted on entry to WB/MWR, so they follow the state
   // exactly and the async reset clears them without waiting for an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= 1'b0;
         sub_q    <= 1'b0;
         base_q   <= '0;
         offset_q <= '0;
         rd_q     <= '0;
         addr_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         reg_we_q <= 1'b0;
         mem_we_q <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         reg_we_q <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q     <= op;
                  sub_q    <= sub;
                  base_q   <= base;
                  offset_q <= offset;
                  rd_q     <= rd;
                  err_q    <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (addr_neg_d) begin
                  // The wrapped difference is never captured, so mem_ads
                  // never shows a negative (>= 32 from a subtraction) address.
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  addr_q <= add_res;
                  if (op_q) begin
                     mem_we_q <= 1'b1;
                     state_q  <= S_MWR;
                  end else begin
                     state_q <= S_MRD;
                  end
               end
            end
            S_MRD: begin
               // Memory read data appears on dout during WB.
               reg_we_q <= 1'b1;
               state_q  <= S_WB;
            end
            S_WB: begin
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_MWR: begin
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign add_a     = base_q;
   assign add_b     = offset_q;
   assign add_sinal = sub_q;
   assign reg_we    = reg_we_q;
   assign reg_rw    = rd_q;
   assign reg_ra    = rd_q;
   assign mem_we    = mem_we_q;
   assign mem_ads   = addr_q;

endmodule

// File: tb/tb_controle_ldst.sv
// Directed bench for controle_ldst with behavioural somador, registrador
// and memoria models wired around the controller.
module tb_controle_ldst;

   logic       clk;
   logic       rst;
   logic       start;
   logic       op;
   logic [4:0] base;
   logic [4:0] offset;
   logic       sub;
   logic [4:0] rd;
   logic       busy;
   logic       done;
   logic       err;
   logic [4:0] add_a;
   logic [4:0] add_b;
   logic       add_sinal;
   logic [5:0] add_res;
   logic       reg_we;
   logic [4:0] reg_rw;
   logic [4:0] reg_ra;
   logic       mem_we;
   logic [5:0] mem_ads;

   int errors = 0;
   int checks = 0;

   // Datapath models
   logic [63:0] rf  [32] = '{default: 64'h0};
   logic [63:0] mem [64] = '{default: 64'h0};
   logic [63:0] mem_dout;
   logic [63:0] doutA;
   logic        tb_rf_we;
   logic [4:0]  tb_rf_idx;
   logic [63:0] tb_rf_data;

   controle_ldst dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .base      (base),
      .offset    (offset),
      .sub       (sub),
      .rd        (rd),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_sinal (add_sinal),
      .add_res   (add_res),
      .reg_we    (reg_we),
      .reg_rw    (reg_rw),
      .reg_ra    (reg_ra),
      .mem_we    (mem_we),
      .mem_ads   (mem_ads)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // somador: 6-bit sum or difference of two 5-bit operands
   always_comb begin
      if (add_sinal) add_res = {1'b0, add_a} - {1'b0, add_b};
      else           add_res = {1'b0, add_a} + {1'b0, add_b};
   end

   // registrador: synchronous write, combinational read port A
   assign doutA = rf[reg_ra];
   always @(posedge clk) begin
      if (reg_we)        rf[reg_rw]    <= mem_dout;
      else if (tb_rf_we) rf[tb_rf_idx] <= tb_rf_data;
   end

   // memoria: synchronous read and write
   always @(posedge clk) begin
      if (mem_we) mem[mem_ads] <= doutA;
      mem_dout <= mem[mem_ads];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic junk_start();
      op     = 1'b0;
      base   = 5'd0;
      offset = 5'd15;
      sub    = 1'b0;
      rd     = 5'd7;
      start  = 1'b1;
   endtask

   // Issue one command and observe it until a few cycles past DONE.
   task automatic run_cmd(input logic c_op, input logic [4:0] c_base, input logic [4:0] c_off,
                          input logic c_sub, input logic [4:0] c_rd, input logic pulse_busy,
                          output int cyc, output int nmw, output int nrw, output int ndone,
                          output logic [5:0] ads, output logic err_done);
      op     = c_op;
      base   = c_base;
      offset = c_off;
      sub    = c_sub;
      rd     = c_rd;
      start  = 1'b1;
      tick();
      start    = 1'b0;
      cyc      = 1;
      nmw      = 0;
      nrw      = 0;
      ndone    = 0;
      ads      = '0;
      err_done = 1'b0;
      while (!done && cyc < 12) begin
         if (mem_we) begin nmw++; ads = mem_ads; end
         if (reg_we) begin nrw++; ads = mem_ads; end
         if (pulse_busy && cyc == 2) junk_start();
         tick();
         start = 1'b0;
         cyc++;
      end
      err_done = err;
      if (done)   ndone++;
      if (mem_we) nmw++;
      if (reg_we) nrw++;
      if (pulse_busy) junk_start();
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (done)   ndone++;
         if (mem_we) nmw++;
         if (reg_we) nrw++;
         tick();
      end
   endtask

   int         cyc;
   int         nmw;
   int         nrw;
   int         ndone;
   logic [5:0] ads;
   logic       err_done;
   int         late_done;

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      op         = 1'b0;
      base       = '0;
      offset     = '0;
      sub        = 1'b0;
      rd         = '0;
      tb_rf_we   = 1'b0;
      tb_rf_idx  = '0;
      tb_rf_data = '0;
      #1;
      chk("rst_busy",   64'(busy),      64'd0);
      chk("rst_done",   64'(done),      64'd0);
      chk("rst_err",    64'(err),       64'd0);
      chk("rst_reg_we", 64'(reg_we),    64'd0);
      chk("rst_mem_we", 64'(mem_we),    64'd0);
      chk("rst_add",    64'({add_a, add_b, add_sinal}), 64'd0);
      chk("rst_rw_ra",  64'({reg_rw, reg_ra}), 64'd0);
      chk("rst_ads",    64'(mem_ads),   64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Preload R1 and R3 through the bench-side register port
      tb_rf_we = 1'b1; tb_rf_idx = 5'd1; tb_rf_data = 64'hDEAD_BEEF_0000_0010;
      tick();
      tb_rf_idx = 5'd3; tb_rf_data = 64'h1234;
      tick();
      tb_rf_we = 1'b0;

      // STORE R1 -> mem[16]
      run_cmd(1'b1, 5'd0, 5'd16, 1'b0, 5'd1, 1'b0, cyc, nmw, nrw, ndone, ads, err_done);
      chk("pre_store_lat",  64'(cyc), 64'd3);
      chk("pre_store_mem",  mem[16],  64'hDEAD_BEEF_0000_0010);

      // LOAD mem[16] -> R10
      run_cmd(1'b0, 5'd0, 5'd16, 1'b0, 5'd10, 1'b0, cyc, nmw, nrw, ndone, ads, err_done);
      chk("load_lat",   64'(cyc),   64'd4);
      chk("load_rwe",   64'(nrw),   64'd1);
      chk("load_mwe",   64'(nmw),   64'd0);
      chk("load_ads",   64'(ads),   64'd16);
      chk("load_r10",   rf[10],     64'hDEAD_BEEF_0000_0010);
      chk("load_done1", 64'(ndone), 64'd1);

      // STORE R3 -> mem[20-5]
      run_cmd(1'b1, 5'd20, 5'd5, 1'b1, 5'd3, 1'b0, cyc, nmw, nrw, ndone, ads, err_done);
      chk("store_lat", 64'(cyc), 64'd3);
      chk("store_mwe", 64'(nmw), 64'd1);
      chk("store_rwe", 64'(nrw), 64'd0);
      chk("store_ads", 64'(ads), 64'd15);
      chk("store_mem", mem[15],  64'h1234);
      chk("store_err", 64'(err_done), 64'd0);

      // Address boundaries: 31+31 and 5-5
      run_cmd(1'b0, 5'd31, 5'd31, 1'b0, 5'd11, 1'b0, cyc, nmw, nrw, ndone, ads, err_done);
      chk("bnd_hi_ads", 64'(ads),      64'd62);
      chk("bnd_hi_err", 64'(err_done), 64'd0);
      chk("bnd_hi_lat", 64'(cyc),      64'd4);
      run_cmd(1'b0, 5'd5, 5'd5, 1'b1, 5'd12, 1'b0, cyc, nmw, nrw, ndone, ads, err_done);
      chk("bnd_lo_ads", 64'(ads),      64'd0);
      chk("bnd_lo_err", 64'(err_done), 64'd0);
      chk("bnd_lo_rwe", 64'(nrw),      64'd1);

      // Address error: 3-4
      run_cmd(1'b1, 5'd3, 5'd4, 1'b1, 5'd3, 1'b0, cyc, nmw, nrw, ndone, ads, err_done);
      chk("err_lat",    64'(cyc),      64'd2);
      chk("err_flag",   64'(err_done), 64'd1);
      chk("err_mwe",    64'(nmw),      64'd0);
      chk("err_rwe",    64'(nrw),      64'd0);
      chk("err_sticky", 64'(err),      64'd1);
      chk("err_busy",   64'(busy),     64'd0);

      // Next valid command clears err: LOAD mem[15] -> R13
      run_cmd(1'b0, 5'd0, 5'd15, 1'b0, 5'd13, 1'b0, cyc, nmw, nrw, ndone, ads, err_done);
      chk("errclr_flag", 64'(err_done), 64'd0);
      chk("errclr_r13",  rf[13],        64'h1234);

      // start pulses while busy and in DONE are ignored
      run_cmd(1'b0, 5'd0, 5'd16, 1'b0, 5'd14, 1'b1, cyc, nmw, nrw, ndone, ads, err_done);
      chk("busy_lat",   64'(cyc),   64'd4);
      chk("busy_done",  64'(ndone), 64'd1);
      chk("busy_rwe",   64'(nrw),   64'd1);
      chk("busy_r14",   rf[14],     64'hDEAD_BEEF_0000_0010);
      chk("busy_r7",    rf[7],      64'h0);
      chk("busy_idle",  64'(busy),  64'd0);

      // Reset in the middle of a STORE, while in MWR
      tb_rf_we = 1'b1; tb_rf_idx = 5'd4; tb_rf_data = 64'hAAAA_5555;
      tick();
      tb_rf_we = 1'b0;
      op = 1'b1; base = 5'd4; offset = 5'd5; sub = 1'b0; rd = 5'd4; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("mwr_mem_we", 64'(mem_we), 64'd1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_mem_we", 64'(mem_we), 64'd0);
      chk("arst_busy",   64'(busy),   64'd0);
      chk("arst_done",   64'(done),   64'd0);
      chk("arst_outs",   64'({add_a, add_b, add_sinal, reg_rw, reg_ra, mem_ads, reg_we, err}), 64'd0);
      tick();
      chk("arst_mem9",   mem[9],      64'h0);
      rst = 1'b0;
      late_done = 0;
      for (int i = 0; i < 5; i++) begin
         if (done || mem_we || reg_we) late_done++;
         tick();
      end
      chk("arst_no_done", 64'(late_done), 64'd0);
      chk("arst_mem9_end", mem[9], 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/controle_ldst.md
# controle_ldst

Load/store sequencer for the register-file/memory datapath. It accepts one command at a time: LOAD copies a memory word into a register, STORE copies a register into memory. For each command it drives the `somador` operands to form the memory address, then sequences the `registrador` write and read ports and the `memoria` write enable. The 64-bit data buses connect directly between the blocks and never pass through this controller: `registrador.din` = `memoria.dout`, and `memoria.din` = `registrador.doutA`.

## Interface
- No parameters. Widths are fixed by the datapath: 5-bit register index, 5-bit address operands, 6-bit memory address.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: command strobe. Sampled only in IDLE.
- `op` in 1: 0 = LOAD, 1 = STORE.
- `base` in 5: address operand A.
- `offset` in 5: address operand B.
- `sub` in 1: 0 gives address = base+offset; 1 gives address = base−offset.
- `rd` in 5: register index. It is the destination for LOAD and the source for STORE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: address error flag. Sticky until the next accepted start.
- `add_a`, `add_b` out 5: to `somador.a` and `somador.b`.
- `add_sinal` out 1: to `somador.sinal`.
- `add_res` in 6: from `somador.soma`.
- `reg_we` out 1: to `registrador.we`.
- `reg_rw` out 5: to `registrador.Rw`.
- `reg_ra` out 5: to `registrador.Ra`.
- `mem_we` out 1: to `memoria.we`.
- `mem_ads` out 6: to `memoria.ads`.

## Operation
- States: IDLE, ADDR, MRD, WB, MWR, DONE.
- IDLE, when start=1: latch op, base, offset, sub and rd into command registers, clear err, go to ADDR. When start=0, stay in IDLE.
- ADDR:
  - add_a, add_b and add_sinal are driven from the latched command. The adder path is combinational.
  - At the edge, capture add_res into addr_q.
  - If sub=1 and base<offset, set err=1 and go to DONE. No memory or register access is made.
  - Otherwise go to MRD for LOAD, or MWR for STORE.
- MRD: mem_ads=addr_q. Memory read is synchronous, so data is valid on dout one cycle later. Go to WB.
- WB: mem_ads=addr_q held, reg_rw=rd, reg_we=1. The register file captures memoria.dout at the edge. Go to DONE.
- MWR: reg_ra=rd, so doutA is combinational. mem_ads=addr_q, mem_we=1. Memory captures doutA at the edge. Go to DONE.
- DONE: done=1 for exactly this cycle. err keeps its value. Go to IDLE.
- reg_we and mem_we are decoded from state only. Each is high for exactly one cycle per successful command and never high outside WB or MWR.
- Address outputs in idle states:
  - mem_ads holds addr_q outside MRD, WB and MWR.
  - reg_rw and reg_ra hold the latched rd.
- Arithmetic:
  - Sum maximum is 31+31=62, which fits in 6 bits, so there is no wrap.
  - A negative difference is never passed to memory.
  - Address 63 is unreachable. Addresses 0 and 62 are both legal.

## Timing
- Reset: state=IDLE. busy, done, err, reg_we and mem_we are 0. add_a, add_b, add_sinal, reg_rw, reg_ra, mem_ads and addr_q are 0.
- Reset asserted mid-command drops every write enable immediately, with no partial write. The aborted command gives no done pulse.
- Latency is counted from the edge that samples start:
  - LOAD: done high in cycle 4. Sequence is ADDR, MRD, WB, DONE.
  - STORE: done high in cycle 3. Sequence is ADDR, MWR, DONE.
  - Error: done high in cycle 2. Sequence is ADDR, DONE.
- start while busy=1, including the DONE cycle, is ignored and never queued. The minimum issue interval equals the command latency plus 1.
- Input fields may change freely after the accepting edge, because only the latched copies are used.

## Test plan
- Reset:
  - Stimulus: assert rst mid-STORE while in MWR.
  - Required: mem_we falls without waiting for a clock edge, and every output reaches its reset value.
  - Check: memory location is unchanged, and no done pulse occurs.
- LOAD:
  - Setup: preload mem[16]=64'hDEAD_BEEF_0000_0010 through a STORE.
  - Stimulus: LOAD base=0, offset=16, sub=0, rd=10.
  - Required: done in cycle 4, and a register-file read of R10 returns 64'hDEAD_BEEF_0000_0010.
- STORE:
  - Setup: R3=64'h1234.
  - Stimulus: STORE base=20, offset=5, sub=1, rd=3.
  - Required: mem_we high for exactly one cycle with mem_ads=15, done in cycle 3, and mem[15]=64'h1234.
- Boundary:
  - Stimulus: LOAD with base=31, offset=31, sub=0, then LOAD with base=5, offset=5, sub=1.
  - Required: mem_ads is 62 for the first and 0 for the second, and err=0 for both.
- Error:
  - Stimulus: STORE base=3, offset=4, sub=1.
  - Required: done in cycle 2 with err=1, and mem_we and reg_we never assert.
  - Follow-up: the next valid start clears err.
- Busy:
  - Stimulus: pulse start with different operands while busy during a LOAD, and again in its DONE cycle.
  - Required: both pulses are ignored. Exactly one done pulse occurs, and only the original rd is written.
